// File: rtl/expr_eval_pkg.sv
// Shared definitions for the expression evaluator and its character classifier.
//   - ASCII constants for the recognised characters
//   - FSM state encoding
//   - character-class enumeration
package expr_eval_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

  typedef enum logic [1:0] {
    StOpnd,  // expecting a digit
    StOper,  // expecting an operator or '='
    StErr    // malformed, absorbing until '='
  } state_e;

  typedef enum logic [2:0] {
    ClsDigit,
    ClsPlus,
    ClsMul,
    ClsEq,
    ClsBad
  } char_cls_e;

endpackage

// File: rtl/expr_eval_char_classify.sv
// Combinational ASCII character classifier.
// Ports:
//   char_i  - 8-bit ASCII character
//   cls_o   - character class (digit, '+', '*', '=', other)
//   digit_o - numeric value of the character when cls_o is ClsDigit, else 0
module expr_eval_char_classify
  import expr_eval_pkg::*;
(
  input  logic [7:0] char_i,
  output char_cls_e  cls_o,
  output logic [3:0] digit_o
);

  always_comb begin
    cls_o   = ClsBad;
    digit_o = 4'd0;
    if (char_i >= CH_0 && char_i <= CH_9) begin
      cls_o   = ClsDigit;
      // '0'..'9' are 0x30..0x39, so the low nibble is the value.
      digit_o = char_i[3:0];
    end else if (char_i == CH_PLUS) begin
      cls_o = ClsPlus;
    end else if (char_i == CH_MUL) begin
      cls_o = ClsMul;
    end else if (char_i == CH_EQ) begin
      cls_o = ClsEq;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Evaluates single-digit expressions of the form digit (op digit)* with op in {'+','*'},
// '*' binding tighter than '+', terminated by '='. One character per cycle.
// Ports:
//   clk      - clock, rising edge
//   clr      - asynchronous active-low reset
//   in_valid - 'in' carries a character this cycle
//   in       - ASCII character
//   ok       - characters since the last terminator form a complete expression
//   partial  - running value acc_sum + acc_prod (meaningful when ok)
//   result   - value of the last successfully terminated expression
//   done     - one-cycle pulse the cycle after '=' is accepted
//   err      - with done: expression was malformed; also high while in the error state
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         ok,
  output logic [W-1:0] partial,
  output logic [W-1:0] result,
  output logic         done,
  output logic         err
);

  char_cls_e  cls;
  logic [3:0] digit;

  expr_eval_char_classify u_classify (
    .char_i  (in),
    .cls_o   (cls),
    .digit_o (digit)
  );

  state_e       state_d, state_q;
  logic [W-1:0] acc_sum_d, acc_sum_q;
  logic [W-1:0] acc_prod_d, acc_prod_q;
  logic [W-1:0] result_d, result_q;
  logic         done_d, done_q;
  logic         err_d, err_q;

  logic [W-1:0] sum_now;
  logic [W-1:0] prod_next;

  // Both wrap modulo 2^W by construction.
  assign sum_now   = acc_sum_q + acc_prod_q;
  assign prod_next = acc_prod_q * W'(digit);

  always_comb begin
    state_d    = state_q;
    acc_sum_d  = acc_sum_q;
    acc_prod_d = acc_prod_q;
    result_d   = result_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StOpnd: begin
          unique case (cls)
            ClsDigit: begin
              acc_prod_d = prod_next;
              state_d    = StOper;
            end
            ClsEq: begin
              // Empty or trailing-operator expression.
              done_d     = 1'b1;
              err_d      = 1'b1;
              acc_sum_d  = '0;
              acc_prod_d = W'(1);
            end
            default: state_d = StErr;
          endcase
        end
        StOper: begin
          unique case (cls)
            ClsPlus: begin
              acc_sum_d  = sum_now;
              acc_prod_d = W'(1);
              state_d    = StOpnd;
            end
            ClsMul: state_d = StOpnd;
            ClsEq: begin
              result_d   = sum_now;
              done_d     = 1'b1;
              acc_sum_d  = '0;
              acc_prod_d = W'(1);
              state_d    = StOpnd;
            end
            default: state_d = StErr;
          endcase
        end
        default: begin
          if (cls == ClsEq) begin
            done_d     = 1'b1;
            err_d      = 1'b1;
            acc_sum_d  = '0;
            acc_prod_d = W'(1);
            state_d    = StOpnd;
          end
        end
      endcase
    end

    // err stays high for as long as the FSM sits in the error state.
    if (state_d == StErr) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= StOpnd;
      acc_sum_q  <= '0;
      acc_prod_q <= W'(1);
      result_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_sum_q  <= acc_sum_d;
      acc_prod_q <= acc_prod_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ok      = (state_q == StOper);
  assign partial = sum_now;
  assign result  = result_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_expr_eval.sv
module tb_expr_eval;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_ch;

  logic        ok16, done16, err16;
  logic [15:0] partial16, result16;
  logic        ok8, done8, err8;
  logic [7:0]  partial8, result8;

  int unsigned n_tests;
  int unsigned n_fail;

  expr_eval #(.W(16)) dut16 (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in_ch),
    .ok       (ok16),
    .partial  (partial16),
    .result   (result16),
    .done     (done16),
    .err      (err16)
  );

  expr_eval #(.W(8)) dut8 (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in_ch),
    .ok       (ok8),
    .partial  (partial8),
    .result   (result8),
    .done     (done8),
    .err      (err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase after the next edge.
  task automatic send_char(input byte c);
    in_valid = 1'b1;
    in_ch    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_ch    = "x";
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_ch    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ok", ok16, 0);
    check("rst_done", done16, 0);
    check("rst_err", err16, 0);
    check("rst_result", result16, 0);
    clr = 1'b1;
    idle_cycle();

    // 1+2*3=
    send_char("1"); check("t1_ok_1", ok16, 1);
    send_char("+"); check("t1_ok_plus", ok16, 0);
    send_char("2"); check("t1_ok_2", ok16, 1);
    send_char("*"); check("t1_ok_mul", ok16, 0); check("t1_done_early", done16, 0);
    send_char("3"); check("t1_ok_3", ok16, 1); check("t1_partial", partial16, 7);
    send_char("=");
    check("t1_done", done16, 1);
    check("t1_err", err16, 0);
    check("t1_result", result16, 7);
    check("t1_ok_eq", ok16, 0);
    idle_cycle();
    check("t1_done_drop", done16, 0);
    check("t1_result_hold", result16, 7);

    // 2*3*4+5= then immediately 0=
    send_str("2*3*4+5=");
    check("t2_done", done16, 1);
    check("t2_err", err16, 0);
    check("t2_result", result16, 29);
    send_str("0=");
    check("t2b_done", done16, 1);
    check("t2b_result", result16, 0);

    // 2=, then 1++2= keeps result at 2
    send_str("2=");
    check("t3_pre_result", result16, 2);
    send_str("1+");
    check("t3_err_first_plus", err16, 0);
    send_char("+"); check("t3_err_second_plus", err16, 1);
    send_char("2"); check("t3_err_digit", err16, 1); check("t3_done_absorb", done16, 0);
    send_char("=");
    check("t3_done", done16, 1);
    check("t3_err_eq", err16, 1);
    check("t3_result_kept", result16, 2);
    idle_cycle();
    check("t3_err_clear", err16, 0);
    check("t3_done_clear", done16, 0);

    // Lone '=' and bad character
    send_char("=");
    check("t3b_done", done16, 1);
    check("t3b_err", err16, 1);
    check("t3b_result", result16, 2);
    send_char("a"); check("t3c_err_bad", err16, 1);
    idle_cycle();
    check("t3c_err_idle", err16, 1);
    check("t3c_done_idle", done16, 0);
    send_char("=");
    check("t3c_done", done16, 1);
    send_char("3"); check("t3c_recover_ok", ok16, 1);
    send_char("5"); check("t3c_multidigit_err", err16, 1);
    send_char("=");
    check("t3c_result_kept", result16, 2);

    // 9*9*9=: 729 at W=16, 217 at W=8
    send_str("9*9*9=");
    check("t4_result16", result16, 729);
    check("t4_result8", result8, 217);
    check("t4_err8", err8, 0);
    check("t4_done8", done8, 1);

    // Asynchronous reset mid-expression
    send_str("1+2");
    check("t5_ok_before", ok16, 1);
    #3 clr = 1'b0;
    #1;
    check("t5_ok_rst", ok16, 0);
    check("t5_result_rst", result16, 0);
    check("t5_done_rst", done16, 0);
    check("t5_err_rst", err16, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    send_str("3=");
    check("t5_result", result16, 3);
    check("t5_done", done16, 1);

    // Idle cycles hold state
    send_str("1+");
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check("t6_ok_idle", ok16, 0);
      check("t6_err_idle", err16, 0);
      check("t6_done_idle", done16, 0);
    end
    send_char("4"); check("t6_partial", partial16, 5);
    send_char("=");
    check("t6_result", result16, 5);
    check("t6_done", done16, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
